// File: rtl/spi_motor_pkg.sv
// spi_motor_pkg: shared types and default constants for the SPI motor controller.
//   state_e : frame receiver FSM states
//   dir_e   : per-channel H-bridge leg encoding (bit0 = forward leg, bit1 = reverse leg)
package spi_motor_pkg;

    localparam int unsigned DEF_N_CH        = 2;
    localparam int unsigned DEF_W           = 8;
    localparam int unsigned DEF_TIMEOUT_CYC = 2_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    // Encoding chosen so both legs can never be high together.
    typedef enum logic [1:0] {
        DIR_COAST = 2'b00,
        DIR_FWD   = 2'b01,
        DIR_REV   = 2'b10
    } dir_e;

endpackage

// File: rtl/spi_motor_ctrl_if.sv
// spi_motor_ctrl_if: SPI frame bus between host (master) and controller (slave).
//   sck  : SPI clock from host
//   sdi  : host -> controller data, MSB first
//   load : frame strobe, high for the whole frame
//   sdo  : controller -> host echo of the previous committed frame
interface spi_motor_ctrl_if;
    logic sck;
    logic sdi;
    logic load;
    logic sdo;

    modport master (output sck, output sdi, output load, input sdo);
    modport slave  (input sck, input sdi, input load, output sdo);
endinterface

// File: rtl/spi_motor_chan.sv
// spi_motor_chan: one motor channel. Holds the active magnitude/direction and
// compares the shared PWM counter against the magnitude.
//   cmd_i    : signed command from the shadow register
//   load_i   : take cmd_i as the new active command (PWM wrap with pending commit)
//   clr_i    : watchdog expiry, force coast immediately
//   cnt_i    : shared free-running PWM counter
//   pwm_en_o, dir_a_o, dir_b_o : registered bridge controls
module spi_motor_chan
    import spi_motor_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] cmd_i,
    input  logic         load_i,
    input  logic         clr_i,
    input  logic [W-2:0] cnt_i,
    output logic         pwm_en_o,
    output logic         dir_a_o,
    output logic         dir_b_o
);

    logic [W-2:0] mag_q, mag_d;
    dir_e         dir_q, dir_d;
    logic         pwm_q;
    logic [W-1:0] neg_c;

    // |cmd| with the most negative value saturated to full scale.
    always_comb begin
        neg_c = (~cmd_i) + W'(1);
        mag_d = cmd_i[W-2:0];
        dir_d = DIR_FWD;
        if (cmd_i[W-1]) begin
            mag_d = neg_c[W-1] ? '1 : neg_c[W-2:0];
            dir_d = DIR_REV;
        end else if (cmd_i == '0) begin
            dir_d = DIR_COAST;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag_q <= '0;
            dir_q <= DIR_COAST;
            pwm_q <= 1'b0;
        end else begin
            if (clr_i) begin
                mag_q <= '0;
                dir_q <= DIR_COAST;
            end else if (load_i) begin
                mag_q <= mag_d;
                dir_q <= dir_d;
            end
            pwm_q <= ~clr_i & (cnt_i < mag_q);
        end
    end

    assign pwm_en_o = pwm_q;
    assign dir_a_o  = dir_q[0];
    assign dir_b_o  = dir_q[1];

endmodule

// File: rtl/spi_motor_ctrl.sv
// spi_motor_ctrl: SPI-commanded multi-channel PWM H-bridge controller with
// shadowed commands, frame length checking, sdo echo and a command watchdog.
//   clk, reset  : system clock, async active-high reset
//   spi         : slave side of the SPI frame bus (sck, sdi, load, sdo)
//   pwm_en      : per-channel PWM bridge enable
//   dir_a/dir_b : per-channel forward/reverse legs
//   frame_err   : last frame had the wrong bit count
//   debug_light : commands are live (valid frame seen, watchdog not expired)
module spi_motor_ctrl
    import spi_motor_pkg::*;
#(
    parameter int unsigned N_CH        = DEF_N_CH,
    parameter int unsigned W           = DEF_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             reset,
    spi_motor_ctrl_if.slave  spi,
    output logic [N_CH-1:0]  pwm_en,
    output logic [N_CH-1:0]  dir_a,
    output logic [N_CH-1:0]  dir_b,
    output logic             frame_err,
    output logic             debug_light
);

    localparam int unsigned NW  = N_CH * W;
    localparam int unsigned BCW = $clog2(NW + 2);
    localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]     sck_sy_q, load_sy_q;
    logic [1:0]     sdi_sy_q;
    state_e         state_q;
    logic [BCW-1:0] bit_cnt_q;
    logic [NW-1:0]  rx_q, shadow_q;
    logic [NW-2:0]  tx_q;
    logic           sdo_q, frame_err_q, pend_q, live_q;
    logic [W-2:0]   pwm_cnt_q;
    logic [WDW-1:0] wd_cnt_q;

    logic           sck_rise_c, load_rise_c, load_fall_c, commit_c, expire_c, apply_c;
    logic [NW-1:0]  tx_load_c;

    // Synchronisers. load resets high so a strobe already asserted at reset
    // release is not mistaken for a new frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sy_q  <= '0;
            sdi_sy_q  <= '0;
            load_sy_q <= '1;
        end else begin
            sck_sy_q  <= {sck_sy_q[1:0], spi.sck};
            sdi_sy_q  <= {sdi_sy_q[0], spi.sdi};
            load_sy_q <= {load_sy_q[1:0], spi.load};
        end
    end

    assign sck_rise_c  = sck_sy_q[1] & ~sck_sy_q[2];
    assign load_rise_c = load_sy_q[1] & ~load_sy_q[2];
    assign load_fall_c = ~load_sy_q[1] & load_sy_q[2];
    assign commit_c    = (state_q == ST_CHECK) && (bit_cnt_q == BCW'(NW));
    // A frame committed in the same cycle as a new load rise is echoed next.
    assign tx_load_c   = commit_c ? rx_q : shadow_q;

    // Frame receiver FSM with shift, echo and shadow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            sdo_q       <= 1'b0;
            shadow_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_rise_c) begin
                        state_q   <= ST_RECV;
                        bit_cnt_q <= '0;
                        tx_q      <= tx_load_c[NW-2:0];
                        sdo_q     <= tx_load_c[NW-1];
                    end
                end
                ST_RECV: begin
                    // A rise coinciding with the load fall is still counted.
                    if (sck_rise_c) begin
                        rx_q  <= {rx_q[NW-2:0], sdi_sy_q[1]};
                        tx_q  <= tx_q << 1;
                        sdo_q <= tx_q[NW-2];
                        if (bit_cnt_q != BCW'(NW + 1)) begin
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end
                    if (load_fall_c) begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (commit_c) begin
                        shadow_q    <= rx_q;
                        frame_err_q <= 1'b0;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                    if (load_rise_c) begin
                        state_q   <= ST_RECV;
                        bit_cnt_q <= '0;
                        tx_q      <= tx_load_c[NW-2:0];
                        sdo_q     <= tx_load_c[NW-1];
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Expiry loses to a commit in the same cycle.
    assign expire_c = live_q && !commit_c && (wd_cnt_q == WDW'(TIMEOUT_CYC - 1));
    assign apply_c  = (&pwm_cnt_q) & pend_q;

    // Shared PWM counter, pending-commit flag and watchdog.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt_q <= '0;
            wd_cnt_q  <= '0;
            pend_q    <= 1'b0;
            live_q    <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + (W-1)'(1);
            if (commit_c) begin
                wd_cnt_q <= '0;
                pend_q   <= 1'b1;
                live_q   <= 1'b1;
            end else begin
                if (&pwm_cnt_q) begin
                    pend_q <= 1'b0;
                end
                if (expire_c) begin
                    live_q <= 1'b0;
                    pend_q <= 1'b0;
                end else if (live_q) begin
                    wd_cnt_q <= wd_cnt_q + WDW'(1);
                end
            end
        end
    end

    // Channel 0 is the first W bits received, i.e. the MSBs of the shadow.
    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        spi_motor_chan #(.W(W)) u_chan (
            .clk      (clk),
            .reset    (reset),
            .cmd_i    (shadow_q[NW-1-i*W -: W]),
            .load_i   (apply_c),
            .clr_i    (expire_c),
            .cnt_i    (pwm_cnt_q),
            .pwm_en_o (pwm_en[i]),
            .dir_a_o  (dir_a[i]),
            .dir_b_o  (dir_b[i])
        );
    end

    assign spi.sdo     = sdo_q;
    assign frame_err   = frame_err_q;
    assign debug_light = live_q;

endmodule

// File: tb/tb_spi_motor_ctrl.sv
// tb_spi_motor_ctrl: self-checking bench for spi_motor_ctrl (N_CH=2, W=8,
// TIMEOUT_CYC=1000) with directed and randomized frames against a frame-level model.
module tb_spi_motor_ctrl;

    localparam int NCH = 2;
    localparam int W   = 8;
    localparam int TO  = 1000;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] pwm_en, dir_a, dir_b;
    logic           frame_err, debug_light;

    spi_motor_ctrl_if bus ();

    spi_motor_ctrl #(.N_CH(NCH), .W(W), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .spi         (bus),
        .pwm_en      (pwm_en),
        .dir_a       (dir_a),
        .dir_b       (dir_b),
        .frame_err   (frame_err),
        .debug_light (debug_light)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level model: last committed frame, frame driving the bridges,
    // watchdog-live flag and last frame error.
    logic [15:0] m_commit, m_act;
    bit          m_live, m_err;
    logic [31:0] echo_got;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int sval(input logic [7:0] b);
        int v;
        v = int'(b);
        if (v >= 128) v -= 256;
        return v;
    endfunction

    function automatic int exp_mag(input int v);
        if (v == -128) return 127;
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [31:0] exp_echo(input int n);
        logic [31:0] e;
        e = '0;
        for (int k = 0; k < n; k++) e = {e[30:0], (k < 16) ? m_commit[15-k] : 1'b0};
        return e;
    endfunction

    // Shift n bits MSB first, capturing sdo just before each sck rise.
    task automatic shift_bits(input logic [31:0] d, input int n);
        for (int k = 0; k < n; k++) begin
            bus.sdi = d[n-1-k];
            tick(4);
            echo_got = {echo_got[30:0], bus.sdo};
            bus.sck = 1'b1;
            tick(4);
            bus.sck = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] d, input int n);
        echo_got = '0;
        bus.load = 1'b1;
        tick(4);
        shift_bits(d, n);
        tick(4);
        bus.load = 1'b0;
    endtask

    // Measure one full PWM period and compare every output against the model.
    task automatic check_outputs(input string tag);
        int duty[NCH];
        int ovl;
        int v;
        for (int ch = 0; ch < NCH; ch++) duty[ch] = 0;
        ovl = 0;
        repeat (128) begin
            @(posedge clk);
            #1;
            for (int ch = 0; ch < NCH; ch++) duty[ch] += int'(pwm_en[ch]);
            if (|(dir_a & dir_b)) ovl++;
        end
        for (int ch = 0; ch < NCH; ch++) begin
            v = sval(m_act[15-8*ch -: 8]);
            chk($sformatf("%s.ch%0d.dir_a", tag, ch), 32'(dir_a[ch]), 32'(v > 0));
            chk($sformatf("%s.ch%0d.dir_b", tag, ch), 32'(dir_b[ch]), 32'(v < 0));
            chk($sformatf("%s.ch%0d.duty", tag, ch), 32'(duty[ch]), 32'(exp_mag(v)));
        end
        chk({tag, ".overlap"}, 32'(ovl), 32'(0));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_err));
        chk({tag, ".debug_light"}, 32'(debug_light), 32'(m_live));
    endtask

    task automatic valid_frame(input string tag, input logic [15:0] d);
        send_frame(32'(d), 16);
        chk({tag, ".echo"}, echo_got, exp_echo(16));
        tick(6);
        m_commit = d;
        m_err    = 1'b0;
        m_live   = 1'b1;
        tick(140);
        m_act = m_commit;
        check_outputs(tag);
    endtask

    task automatic bad_frame(input string tag, input logic [31:0] d, input int n);
        send_frame(d, n);
        chk({tag, ".echo"}, echo_got, exp_echo(n));
        tick(6);
        m_err = 1'b1;
        tick(14);
        check_outputs(tag);
    endtask

    initial begin
        logic [31:0] r;
        int          n;

        reset    = 1'b1;
        bus.sck  = 1'b0;
        bus.sdi  = 1'b0;
        bus.load = 1'b0;
        m_commit = '0;
        m_act    = '0;
        m_live   = 1'b0;
        m_err    = 1'b0;
        echo_got = '0;
        tick(3);
        chk("rst.pwm_en", 32'(pwm_en), 32'(0));
        chk("rst.dir_a", 32'(dir_a), 32'(0));
        chk("rst.dir_b", 32'(dir_b), 32'(0));
        chk("rst.sdo", 32'(bus.sdo), 32'(0));
        chk("rst.frame_err", 32'(frame_err), 32'(0));
        chk("rst.debug_light", 32'(debug_light), 32'(0));
        reset = 1'b0;
        tick(2);
        check_outputs("idle");

        valid_frame("f40c0", 16'h40C0);
        bad_frame("bits15", 32'h7F7F, 15);
        bad_frame("bits17", 32'h1_0101, 17);
        valid_frame("f8000", 16'h8000);

        valid_frame("f6432", 16'h6432);
        valid_frame("echo6432", 16'h55AA);
        chk("echo6432.bits", echo_got, 32'h6432);

        // Watchdog: still live shortly before the timeout, coasting after it.
        valid_frame("wd.arm", 16'h7F81);
        tick(674);
        chk("wd.before", 32'(debug_light), 32'(1));
        tick(70);
        m_live = 1'b0;
        m_act  = '0;
        check_outputs("wd.expired");
        valid_frame("wd.restore", 16'h20E0);

        // Reset mid-frame; the rest of the aborted frame must be ignored.
        bus.load = 1'b1;
        tick(4);
        shift_bits(32'hA5, 8);
        reset = 1'b1;
        tick(2);
        m_commit = '0;
        m_act    = '0;
        m_live   = 1'b0;
        m_err    = 1'b0;
        chk("midrst.pwm_en", 32'(pwm_en), 32'(0));
        chk("midrst.dir_a", 32'(dir_a), 32'(0));
        chk("midrst.dir_b", 32'(dir_b), 32'(0));
        chk("midrst.sdo", 32'(bus.sdo), 32'(0));
        reset = 1'b0;
        tick(2);
        shift_bits(32'h3C, 8);
        tick(4);
        bus.load = 1'b0;
        tick(20);
        check_outputs("abort");
        valid_frame("post_rst", 16'hC37F);

        for (int it = 0; it < 10; it++) begin
            r = $urandom;
            valid_frame($sformatf("rnd%0d", it), r[15:0]);
            n = $urandom_range(0, 17);
            if (n == 16) n = 15;
            bad_frame($sformatf("rndbad%0d", it), $urandom, n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_motor_ctrl.md
SPI_MOTOR_CTRL -- requirements
Module: spi_motor_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of motor channels.
REQ-002 SHALL have parameter W, default 8: bits per channel command, signed two's complement.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 2_000_000: clk cycles without a valid frame before failsafe.
REQ-004 SHALL have port clk, input, 1: sole clock.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port sck, input, 1: SPI clock, asynchronous to clk, at most clk/4.
REQ-007 SHALL have port sdi, input, 1: SPI data in, MSB first.
REQ-008 SHALL have port load, input, 1: frame strobe; high for the whole frame, falling edge ends the frame.
REQ-009 SHALL have port sdo, output, 1: echo of the previous committed frame, MSB first.
REQ-010 SHALL have port pwm_en, output, N_CH: per-channel H-bridge enable, PWM-modulated.
REQ-011 SHALL have port dir_a, output, N_CH: per-channel forward leg.
REQ-012 SHALL have port dir_b, output, N_CH: per-channel reverse leg.
REQ-013 SHALL have port frame_err, output, 1: last frame had the wrong bit count.
REQ-014 SHALL have port debug_light, output, 1: high while a valid frame is active and the watchdog has not expired.

Function
REQ-015 SHALL pass sck, sdi and load through 2-flop synchronisers before use; edges are detected on the synchronised copies.
REQ-016 SHALL implement FSM IDLE -> RECV on load rise, RECV -> CHECK on load fall, and CHECK -> IDLE after one cycle.
REQ-017 SHALL, in RECV, shift sdi into an N_CH*W-bit register on each sck rise and increment a bit counter that saturates at N_CH*W+1.
REQ-018 SHALL count a sck rise that coincides with the load fall before the CHECK evaluation.
REQ-019 SHALL, in CHECK, commit to shadow registers only if count == N_CH*W; channel 0 = first W bits received; frame_err <= 0.
REQ-020 SHALL, in CHECK with count != N_CH*W, discard the frame, set frame_err <= 1, and leave the shadows unchanged.
REQ-021 SHALL, on load rise, load a tx register with the current shadows and drive sdo = its MSB; shift the tx register on each sck rise after sampling.
REQ-022 SHALL derive the magnitude as |cmd|, saturating -2^(W-1) to 2^(W-1)-1.
REQ-023 SHALL set direction as: cmd > 0 -> dir_a=1, dir_b=0; cmd < 0 -> dir_a=0, dir_b=1; cmd = 0 -> both 0 and pwm_en=0 (coast).
REQ-024 SHALL never drive dir_a and dir_b high together on any channel in any cycle.
REQ-025 SHALL use one free-running (W-1)-bit PWM counter shared by all channels, with pwm_en[i] = (cnt < mag[i]); duty = mag/2^(W-1).
REQ-026 SHALL apply committed shadows to the active per-channel mag/dir only on PWM wrap (cnt all-ones -> 0); a second commit before the wrap overwrites the first.
REQ-027 SHALL restart the watchdog counter on every valid commit; on reaching TIMEOUT_CYC it sets active commands to 0 immediately, not at wrap, and debug_light=0.
REQ-028 SHALL, when watchdog expiry and a valid commit occur in the same cycle, let the commit win and restart the watchdog.
REQ-029 SHALL, when load re-rises during CHECK, complete CHECK and enter RECV on the next cycle.

Reset
REQ-030 SHALL, on reset: pwm_en=0, dir_a=0, dir_b=0, sdo=0, frame_err=0, debug_light=0, shadows=0, FSM=IDLE, counters=0, watchdog expired.
REQ-031 SHALL discard a partial frame when reset occurs mid-frame; after release, wait for a fresh load rise.

Structure
REQ-032 SHALL place the FSM state enum, direction encoding and default parameter constants in package spi_motor_pkg.
REQ-033 SHALL implement per-channel magnitude/direction/compare logic as sub-module spi_motor_chan, instantiated N_CH times via generate.

Verification
REQ-034 SHALL verify (N_CH=2, W=8): frame 0x40,0xC0 -> ch0 dir_a=1, 64/128 duty; ch1 dir_b=1, 64/128 duty; frame_err=0; debug_light=1.
REQ-035 SHALL verify: 15-bit frame, then 17-bit frame -> frame_err=1 both times; outputs keep the prior values.
REQ-036 SHALL verify: frame 0x80,0x00 -> ch0 dir_b=1, duty 127/128; ch1 coast (all 0).
REQ-037 SHALL verify with TIMEOUT_CYC=1000: a valid frame followed by 1000 idle cycles -> all outputs 0 and debug_light=0; the next valid frame restores drive.
REQ-038 SHALL verify: frame 0x64,0x32, then a second frame -> sdo bits during the second frame equal 0x6432 MSB first.
REQ-039 SHALL verify: reset pulsed after 8 bits -> all outputs 0; a following full frame commits correctly.
